// File: rtl/instruction_loader_pkg.sv
// Shared constants and FSM encoding for the instruction loader and the
// instruction memory it feeds.
package instruction_loader_pkg;

  localparam int IMEM_DEPTH_WORDS = 256;
  localparam int INSTR_WIDTH      = 32;
  localparam int ADDR_SHIFT       = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_BYTE   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  typedef struct packed {
    logic byte_ready;
    logic cpu_hold;
    logic done;
    logic error;
  } status_t;

  // Status flags are registered alongside the state they belong to.
  function automatic status_t status_for(state_e s);
    status_t st;
    st.byte_ready = (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_BYTE);
    st.cpu_hold   = st.byte_ready || (s == S_WRITE) || (s == S_ERROR);
    st.done       = (s == S_DONE);
    st.error      = (s == S_ERROR);
    return st;
  endfunction

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Big-endian word assembler: shifts in stream bytes and flags the 4th one.
// Only three bytes are stored; the fourth is presented live so the full word
// is available in the same cycle it arrives.
module instruction_loader_word_assembler
  import instruction_loader_pkg::*;
(
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   clear_i,
  input  logic                   load_i,
  input  logic [7:0]             byte_i,
  output logic [INSTR_WIDTH-1:0] word_o,
  output logic                   last_o
);

  logic [INSTR_WIDTH-9:0] word_q;
  logic [1:0]             cnt_q;

  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      word_q <= '0;
      cnt_q  <= 2'd0;
    end else if (load_i) begin
      word_q <= {word_q[INSTR_WIDTH-17:0], byte_i};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  assign word_o = {word_q, byte_i};
  assign last_o = (cnt_q == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed byte stream into instruction memory as big-endian
// 32-bit words, holding the CPU while the program image is incomplete.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int MAX_WORDS = IMEM_DEPTH_WORDS,
  parameter int BASE_WORD = 0,
  parameter int LEN_WIDTH = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [7:0]             byte_in_i,
  input  logic                   byte_valid_i,
  output logic                   byte_ready_o,
  output logic                   mem_we_o,
  output logic [31:0]            mem_addr_o,
  output logic [INSTR_WIDTH-1:0] mem_wdata_o,
  output logic                   cpu_hold_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [15:0]            words_loaded_o
);

  state_e                 state_q;
  status_t                status_q;
  logic                   mem_we_q;
  logic [31:0]            mem_addr_q;
  logic [INSTR_WIDTH-1:0] mem_wdata_q;
  logic [15:0]            words_loaded_q;
  logic [7:0]             len_hi_q;
  logic [LEN_WIDTH-1:0]   len_q;

  logic                   xfer;
  logic                   start_ok;
  logic [15:0]            hdr;
  logic [INSTR_WIDTH-1:0] asm_word;
  logic                   asm_last;

  assign xfer     = byte_valid_i && status_q.byte_ready;
  assign start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                (state_q == S_ERROR));
  assign hdr      = {len_hi_q, byte_in_i};

  instruction_loader_word_assembler u_asm (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear_i (start_ok),
    .load_i  (xfer && (state_q == S_BYTE)),
    .byte_i  (byte_in_i),
    .word_o  (asm_word),
    .last_o  (asm_last)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      status_q       <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      words_loaded_q <= '0;
      len_hi_q       <= '0;
      len_q          <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q  <= S_LEN_HI;
            status_q <= status_for(S_LEN_HI);
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi_q <= byte_in_i;
            state_q  <= S_LEN_LO;
            status_q <= status_for(S_LEN_LO);
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_q <= LEN_WIDTH'(hdr);
            if (hdr == '0) begin
              state_q  <= S_DONE;
              status_q <= status_for(S_DONE);
            end else if (int'(hdr) > (MAX_WORDS - BASE_WORD)) begin
              state_q  <= S_ERROR;
              status_q <= status_for(S_ERROR);
            end else begin
              state_q  <= S_BYTE;
              status_q <= status_for(S_BYTE);
            end
          end
        end
        S_BYTE: begin
          // The write strobe and its address/data are set up on the 4th byte
          // so they are all valid for the whole WRITE cycle.
          if (xfer && asm_last) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= (32'(BASE_WORD) + 32'(words_loaded_q)) << ADDR_SHIFT;
            mem_wdata_q <= asm_word;
            state_q     <= S_WRITE;
            status_q    <= status_for(S_WRITE);
          end
        end
        S_WRITE: begin
          words_loaded_q <= words_loaded_q + 16'd1;
          if ((words_loaded_q + 16'd1) == 16'(len_q)) begin
            state_q  <= S_DONE;
            status_q <= status_for(S_DONE);
          end else begin
            state_q  <= S_BYTE;
            status_q <= status_for(S_BYTE);
          end
        end
        S_DONE, S_ERROR: begin
          if (start_i) begin
            words_loaded_q <= '0;
            state_q        <= S_LEN_HI;
            status_q       <= status_for(S_LEN_HI);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          status_q <= status_for(S_IDLE);
        end
      endcase
    end
  end

  assign byte_ready_o   = status_q.byte_ready;
  assign cpu_hold_o     = status_q.cpu_hold;
  assign done_o         = status_q.done;
  assign error_o        = status_q.error;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign words_loaded_o = words_loaded_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: two instances (BASE_WORD 0 and 1)
// share one stimulus stream; writes are checked against per-instance queues.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        srst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        ready0, we0, hold0, done0, err0;
  logic [31:0] addr0, wdata0;
  logic [15:0] wl0;
  logic        ready1, we1, hold1, done1, err1;
  logic [31:0] addr1, wdata1;
  logic [15:0] wl1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];
  int  tests = 0;
  int  fails = 0;

  always #5 clk = ~clk;

  instruction_loader #(.MAX_WORDS(256), .BASE_WORD(0), .LEN_WIDTH(16)) dut0 (
    .clock_i(clk), .reset_i(srst), .start_i(start), .byte_in_i(byte_in),
    .byte_valid_i(byte_valid), .byte_ready_o(ready0), .mem_we_o(we0),
    .mem_addr_o(addr0), .mem_wdata_o(wdata0), .cpu_hold_o(hold0),
    .done_o(done0), .error_o(err0), .words_loaded_o(wl0)
  );

  instruction_loader #(.MAX_WORDS(256), .BASE_WORD(1), .LEN_WIDTH(16)) dut1 (
    .clock_i(clk), .reset_i(srst), .start_i(start), .byte_in_i(byte_in),
    .byte_valid_i(byte_valid), .byte_ready_o(ready1), .mem_we_o(we1),
    .mem_addr_o(addr1), .mem_wdata_o(wdata1), .cpu_hold_o(hold1),
    .done_o(done1), .error_o(err1), .words_loaded_o(wl1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      wr_t e;
      check("dut0_ready_in_write", 32'(ready0), 32'd0);
      check("dut0_write_expected", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        $display("[TB] dut0 write addr=%h data=%h", addr0, wdata0);
        check("dut0_addr", addr0, e.addr);
        check("dut0_data", wdata0, e.data);
      end
    end
    if (we1 === 1'b1) begin
      wr_t e;
      check("dut1_ready_in_write", 32'(ready1), 32'd0);
      check("dut1_write_expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        $display("[TB] dut1 write addr=%h data=%h", addr1, wdata1);
        check("dut1_addr", addr1, e.addr);
        check("dut1_data", wdata1, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int guard;
    while (int'($urandom_range(99)) < gap_pct) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    guard      = 0;
    while (ready0 !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_timeout", 32'(guard < 20), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] len, input int gap_pct);
    send_byte(len[15:8], gap_pct);
    send_byte(len[7:0], gap_pct);
  endtask

  task automatic push_exp(input int idx, input logic [31:0] w);
    q0.push_back('{addr: 32'(idx * 4), data: w});
    q1.push_back('{addr: 32'((idx + 1) * 4), data: w});
  endtask

  task automatic send_word(input int idx, input logic [31:0] w, input int gap_pct);
    push_exp(idx, w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap_pct);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    repeat (2) @(negedge clk);
    srst = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (done0 !== 1'b1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("done_timeout", 32'(guard < 60), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    srst = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    srst = 1'b0;

    // Reset state
    check("rst_ready", 32'(ready0), 32'd0);
    check("rst_we", 32'(we0), 32'd0);
    check("rst_hold", 32'(hold0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_error", 32'(err0), 32'd0);
    check("rst_addr", addr0, 32'd0);
    check("rst_wdata", wdata0, 32'd0);
    check("rst_words", 32'(wl0), 32'd0);

    // 1: two-word program, valid held high
    pulse_start();
    check("t1_hold_lenhi", 32'(hold0), 32'd1);
    check("t1_ready_lenhi", 32'(ready0), 32'd1);
    send_header(16'd2, 0);
    send_word(0, 32'h12345678, 0);
    send_word(1, 32'h9ABCDEF0, 0);
    check("t1_we_latency", 32'(we0), 32'd1);
    check("t1_ready_write", 32'(ready0), 32'd0);
    @(negedge clk);
    check("t1_done", 32'(done0), 32'd1);
    check("t1_hold", 32'(hold0), 32'd0);
    check("t1_words0", 32'(wl0), 32'd2);
    check("t1_words1", 32'(wl1), 32'd2);
    check("t1_q_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("[TB] test1 two-word load complete");

    // 2: zero-length program
    pulse_start();
    check("t2_done_cleared", 32'(done0), 32'd0);
    check("t2_words_cleared", 32'(wl0), 32'd0);
    send_header(16'd0, 0);
    check("t2_done", 32'(done0), 32'd1);
    check("t2_hold", 32'(hold0), 32'd0);
    repeat (4) @(negedge clk);
    check("t2_words", 32'(wl0), 32'd0);
    $display("[TB] test2 zero-length load complete");

    // 3: oversize length, recovery, then the per-instance limit boundary
    pulse_start();
    send_header(16'd257, 0);
    check("t3_err0", 32'(err0), 32'd1);
    check("t3_err1", 32'(err1), 32'd1);
    check("t3_hold", 32'(hold0), 32'd1);
    check("t3_done", 32'(done0), 32'd0);
    check("t3_ready", 32'(ready0), 32'd0);
    repeat (3) @(negedge clk);
    pulse_start();
    check("t3_err_cleared", 32'(err0), 32'd0);
    send_header(16'd1, 0);
    send_word(0, 32'hCAFEF00D, 0);
    wait_done();
    check("t3_recover_err0", 32'(err0), 32'd0);
    check("t3_recover_done1", 32'(done1), 32'd1);
    pulse_start();
    send_header(16'd256, 0);
    check("t3_len256_err0", 32'(err0), 32'd0);
    check("t3_len256_err1", 32'(err1), 32'd1);
    check("t3_len256_ready0", 32'(ready0), 32'd1);
    do_reset();
    check("t3_reset_hold", 32'(hold0), 32'd0);
    $display("[TB] test3 length limit checks complete");

    // 4: random valid gaps
    pulse_start();
    send_header(16'd3, 50);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      send_word(i, w, 50);
    end
    wait_done();
    check("t4_words", 32'(wl0), 32'd3);
    @(negedge clk);
    check("t4_q_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("[TB] test4 gapped three-word load complete");

    // 5: reset in the middle of word 1
    pulse_start();
    send_header(16'd2, 0);
    send_word(0, 32'h0BADBEEF, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset();
    check("t5_hold", 32'(hold0), 32'd0);
    check("t5_ready", 32'(ready0), 32'd0);
    check("t5_done", 32'(done0), 32'd0);
    check("t5_words", 32'(wl0), 32'd0);
    check("t5_wdata", wdata0, 32'd0);
    check("t5_addr1", addr1, 32'd0);
    repeat (6) @(negedge clk);
    check("t5_q_empty", 32'(q0.size() + q1.size()), 32'd0);
    pulse_start();
    send_header(16'd1, 0);
    send_word(0, 32'h55AA33CC, 0);
    wait_done();
    check("t5_fresh_words", 32'(wl0), 32'd1);
    $display("[TB] test5 reset abort complete");

    // 6: start mid-load is ignored; restart after done
    pulse_start();
    send_header(16'd2, 0);
    send_word(0, 32'hA1B2C3D4, 0);
    push_exp(1, 32'hE5F60718);
    send_byte(8'hE5, 0);
    pulse_start();
    check("t6_ignore_hold", 32'(hold0), 32'd1);
    check("t6_ignore_ready", 32'(ready0), 32'd1);
    send_byte(8'hF6, 0);
    send_byte(8'h07, 0);
    send_byte(8'h18, 0);
    wait_done();
    check("t6_words0", 32'(wl0), 32'd2);
    check("t6_words1", 32'(wl1), 32'd2);
    pulse_start();
    check("t6_restart_words1", 32'(wl1), 32'd0);
    check("t6_restart_done1", 32'(done1), 32'd0);
    check("t6_restart_hold1", 32'(hold1), 32'd1);
    send_header(16'd1, 0);
    send_word(0, 32'h600DC0DE, 0);
    wait_done();
    check("t6_words_after", 32'(wl1), 32'd1);
    @(negedge clk);
    check("t6_q_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("[TB] test6 restart checks complete");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
